// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared types and constants for the pulse meter slice.
//   state_t       - measurement FSM states (IDLE, ARM, MEASURE)
//   DEF_CNT_W     - default run-length counter width
//   DEF_SYNC_STAGES - default input synchronizer depth (minimum 2)
//   sat_value()   - saturation value 2^w-1 for a counter of width w
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    function automatic int unsigned sat_value(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// sync_edge: multi-flop synchronizer followed by a one-cycle-delayed copy for edge detection.
//   clock     in  sole clock
//   reset     in  synchronous active-low reset; clears every flop to 0
//   d         in  asynchronous input
//   s         out synchronized level (output of the last synchronizer flop)
//   edge_seen out s differs from its value one cycle earlier
module sync_edge
    import pulse_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic edge_seen
);

    // SYNC_STAGES must be at least 2; the shift below relies on that.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign edge_seen = s ^ prev_q;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures the length of every high and low run of an asynchronous input.
//   clock   in  sole clock, rising edge
//   reset   in  synchronous active-low reset
//   enable  in  1 = measuring; 0 = idle with the run counter cleared
//   signal  in  asynchronous pulse input
//   ready   in  consumer takes the current result when valid && ready
//   valid   out result register holds an unconsumed measurement
//   width   out run length in clock cycles, saturating at 2^CNT_W-1
//   level   out level of the measured run (1 = high pulse, 0 = low gap)
//   ovf     out run reached the saturation value; width is saturated
//   lost    out sticky: a completed run was dropped because the result register was full
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             signal,
    input  logic             ready,
    output logic             valid,
    output logic [CNT_W-1:0] width,
    output logic             level,
    output logic             ovf,
    output logic             lost
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_value(CNT_W));

    logic s;
    logic edge_seen;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock     (clock),
        .reset     (reset),
        .d         (signal),
        .s         (s),
        .edge_seen (edge_seen)
    );

    // Measurement FSM and run counter
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic             res_vld;
    logic [CNT_W-1:0] res_width;
    logic             res_level;
    logic             res_ovf;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        res_vld   = 1'b0;
        res_width = cnt_q;
        // On an edge the finished run had the opposite level to the new synchronized value.
        res_level = ~s;
        res_ovf   = sat_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ARM;
                end
                ARM: begin
                    // The run in progress at enable time has an unknown start; skip it.
                    if (edge_seen) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_W'(1);
                        sat_d   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (edge_seen) begin
                        res_vld = 1'b1;
                        cnt_d   = CNT_W'(1);
                        sat_d   = 1'b0;
                    end else if (cnt_q != SAT) begin
                        cnt_d = cnt_q + 1'b1;
                        sat_d = ((cnt_q + 1'b1) == SAT);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            endcase
        end
    end

    // Result register with valid/ready handshake
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             lost_q, lost_d;

    always_comb begin
        valid_d = valid_q;
        width_d = width_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        lost_d  = lost_q;

        if (res_vld) begin
            // A consumed slot can be refilled in the same cycle.
            if (!valid_q || ready) begin
                valid_d = 1'b1;
                width_d = res_width;
                level_d = res_level;
                ovf_d   = res_ovf;
            end else begin
                lost_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            width_q <= '0;
            level_q <= 1'b0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            width_q <= width_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            lost_q  <= lost_d;
        end
    end

    assign valid = valid_q;
    assign width = width_q;
    assign level = level_q;
    assign ovf   = ovf_q;
    assign lost  = lost_q;

endmodule
